jc_slot_sched: RTL and testbench
================================

# jc_slot_sched

Time-slot scheduler that shares one downstream resource among up to N_REQ requesters. A Johnson-counter ring provides 2·STAGES time slots, and a programmable ownership table assigns each slot to one requester. The FSM grants the resource to the slot owner, holds the grant until that requester signals done or a hold timeout expires, and only then advances the ring. The block sits between requesting engines and the shared resource, replacing free-running Johnson-counter phase decoders.

## Interface
- N_REQ, 4: number of requesters (2..8).
- STAGES, 5: Johnson ring length; slots = 2·STAGES = 10.
- HOLD_MAX, 8: maximum grant length in cycles before forced release.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  scheduler run enable.
- cfg_we  in  1  ownership-table write strobe.
- cfg_slot  in  4  slot index to write.
- cfg_owner  in  3  requester index to store for cfg_slot.
- req  in  N_REQ  per-requester request level.
- done  in  N_REQ  per-requester completion pulse.
- gnt  out  N_REQ  one-hot grant, registered.
- slot  out  4  current slot index, 0..9.
- jstate  out  STAGES  raw Johnson ring state.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse on forced release.

## Operation
- Ring advance: jstate shifts left, and the new bit0 = ~jstate[STAGES-1].
  - Sequence: 00000 → 00001 → 00011 → … → 11111 → 11110 → … → 10000 → 00000.
- Slot decode:
  - If jstate[msb]=0: slot = popcount(jstate).
  - Otherwise: slot = 2·STAGES − popcount(jstate).
- Illegal ring state (not one of the 10 legal codes): the next clock loads 00000. No grant is issued from an illegal state.
- Ownership table: 2·STAGES entries.
  - Reset value: entry i = i mod N_REQ.
  - Writes with cfg_slot ≥ 2·STAGES or cfg_owner ≥ N_REQ are ignored.
  - Writes are accepted in any state and take effect at the next SCAN evaluation.
- FSM states: IDLE, SCAN, GRANT.
  - IDLE: ring held. Go to SCAN when en=1.
  - SCAN, en=0: go to IDLE.
  - SCAN, req[owner(slot)]=1: assert gnt[owner], clear the hold counter, go to GRANT. The ring holds.
  - SCAN, owner not requesting: advance the ring one step and stay in SCAN (see Configuration).
  - GRANT, done[granted]=1: drop gnt, advance the ring, go to SCAN if en=1, else IDLE.
  - GRANT, hold counter = HOLD_MAX−1 without done: same exit as done, plus a timeout pulse.
  - GRANT: done from non-granted requesters is ignored. Deasserting req does not revoke the grant. en=0 does not abort the grant; the FSM exits to IDLE after release.
- gnt is always one-hot or zero.

## Timing
- Reset values:
  - gnt=0, busy=0, timeout=0.
  - jstate=00000, slot=0.
  - State = IDLE, hold counter = 0, ownership table at its default.
- Grant latency: req sampled in the SCAN cycle t; gnt and busy are high at t+1.
- Release: done at cycle t while in GRANT; gnt=0, busy=0 and the new slot are visible at t+1.
- Minimum grant length: 1 cycle. done may coincide with the first gnt cycle.
- Maximum grant length: HOLD_MAX cycles. timeout is high in the cycle gnt falls.
- Idle-slot cost: 1 cycle per unrequested slot.
- Wrap: slot 9 advances to slot 0 with no extra cycle.
- Simultaneous done and timeout-limit cycle: treated as done, and timeout stays 0.
- Reset asserted mid-grant: gnt drops asynchronously and all state returns to reset values.

## Configuration
- JC_WORK_CONSERVE_EN defined: in SCAN, if the slot owner is not requesting but another requester is, grant the first requesting index after the owner (modulo N_REQ). The ring holds during that grant and advances on its release, exactly as for an owner grant.
- JC_WORK_CONSERVE_EN undefined: slots without a requesting owner are skipped. Strict TDM behaviour.

## Structure
- Package jc_pkg holds:
  - FSM state enum (IDLE, SCAN, GRANT).
  - NSLOTS = 2·STAGES.
  - Slot index width constant.
  - Default-owner function.
- Sub-module jc_ring holds the Johnson register, the advance/hold control, the slot decode and illegal-state correction. Inputs: clk, rst, adv. Outputs: jstate, slot, legal.
- The FSM, ownership table and hold counter live in jc_slot_sched.

## Test plan
- Default table, en=1, req=4'b1111, each done pulsed 1 cycle after gnt: gnt order is 0,1,2,3,0,1,2,3,0,1, then wraps to slot 0 with jstate=00000.
- Write slot 3 owner=0, req=4'b0001 only, macro undefined: grants occur at slots 0, 3, 4, 8. Slots 1, 2, 5, 6, 7, 9 each cost 1 cycle.
- req=4'b0010 with no done: gnt[1] stays high for exactly 8 cycles, then timeout pulses once and slot advances to 2.
- Force jstate=10101 via hierarchical deposit: the next clock gives jstate=00000, slot=0, with no grant in between.
- With the macro defined, slot 0 owner idle and req=4'b0100: gnt[2] at t+1. Without the macro, the same stimulus gives no grant until slot 2.
- Assert rst low during GRANT: gnt=0 immediately. After release, the FSM is in IDLE with jstate=00000 and the default ownership table restored.

Source files
------------

// File: rtl/jc_pkg.sv
// Shared types and constants for the Johnson-ring slot scheduler.
// Slot geometry defaults, FSM state encoding and the reset ownership map.
package jc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } jc_state_e;

  localparam int STAGES_DFLT = 5;
  localparam int NSLOTS      = 2 * STAGES_DFLT;
  localparam int SLOT_W      = 4;
  localparam int OWN_W       = 3;

  // Reset ownership: requesters take slots round-robin.
  function automatic logic [OWN_W-1:0] default_owner(input int idx, input int n_req);
    default_owner = OWN_W'(idx % n_req);
  endfunction

endpackage

// File: rtl/jc_ring.sv
// Johnson-counter slot ring: advances one step per adv, decodes the slot index.
// Illegal codes are flagged (legal=0) and replaced by 00000 on the next clock.
module jc_ring
  import jc_pkg::*;
#(
  parameter int STAGES = STAGES_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [STAGES-1:0] jstate,
  output logic [SLOT_W-1:0] slot,
  output logic              legal
);

  logic [STAGES-1:0] jq;
  logic [STAGES-1:0] jinc;
  logic [STAGES-1:0] jinv;
  logic [STAGES-1:0] jinv_inc;
  logic [SLOT_W-1:0] ones;

  // Legal codes are 0*1* (filling) or 1*0* (draining): a single run of ones
  // anchored at one end, so x & (x+1) clears for one of x or ~x.
  always_comb begin
    jinc     = jq + STAGES'(1);
    jinv     = ~jq;
    jinv_inc = jinv + STAGES'(1);
    legal    = ((jq & jinc) == '0) || ((jinv & jinv_inc) == '0);
    ones     = SLOT_W'($countones(jq));
    slot     = jq[STAGES-1] ? (SLOT_W'(2 * STAGES) - ones) : ones;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jq <= '0;
    end else if (!legal) begin
      jq <= '0;
    end else if (adv) begin
      jq <= {jq[STAGES-2:0], ~jq[STAGES-1]};
    end
  end

  assign jstate = jq;

endmodule

// File: rtl/jc_slot_sched.sv
// Slot scheduler: grants the shared resource to each slot's owner; gnt 1 cycle after req is seen in SCAN.
// Grant held until done or HOLD_MAX cycles; JC_WORK_CONSERVE_EN lends an idle owner's slot to the next requester.
module jc_slot_sched
  import jc_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int STAGES   = STAGES_DFLT,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [OWN_W-1:0]  cfg_owner,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  output logic [N_REQ-1:0]  gnt,
  output logic [SLOT_W-1:0] slot,
  output logic [STAGES-1:0] jstate,
  output logic              busy,
  output logic              timeout
);

  localparam int NS = 2 * STAGES;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  jc_state_e          st;
  logic [OWN_W-1:0]   own [NS];
  logic [OWN_W-1:0]   cur_own;
  logic [OWN_W-1:0]   pick;
  logic [OWN_W-1:0]   sel_own;
  logic [N_REQ-1:0]   own_oh;
  logic [HW-1:0]      hold;
  logic               legal;
  logic               hit;
  logic               wc_hit;
  logic               done_g;
  logic               release_g;
  logic               adv;

  jc_ring #(.STAGES(STAGES)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .jstate (jstate),
    .slot   (slot),
    .legal  (legal)
  );

  always_comb begin
    cur_own = (int'(slot) < NS) ? own[slot] : '0;
    own_oh  = N_REQ'(1) << cur_own;
    hit     = |(req & own_oh);
  end

`ifdef JC_WORK_CONSERVE_EN
  logic [2*N_REQ-1:0] req2;

  // Rotate so bit i is requester owner+i; the lowest set offset wins.
  always_comb begin
    req2   = {req, req} >> cur_own;
    wc_hit = 1'b0;
    pick   = cur_own;
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (req2[i]) begin
        wc_hit = 1'b1;
        pick   = OWN_W'((int'(cur_own) + i) % N_REQ);
      end
    end
  end
`else
  assign wc_hit = 1'b0;
  assign pick   = cur_own;
`endif

  assign sel_own   = hit ? cur_own : pick;
  assign done_g    = |(done & gnt);
  assign release_g = (st == GRANT) && (done_g || (hold == HW'(HOLD_MAX - 1)));
  assign busy      = (st == GRANT);

  always_comb begin
    adv = 1'b0;
    case (st)
      SCAN:    adv = en && legal && !hit && !wc_hit;
      GRANT:   adv = release_g;
      default: adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      gnt     <= '0;
      hold    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (st)
        IDLE: begin
          if (en) st <= SCAN;
        end
        SCAN: begin
          if (!en) begin
            st <= IDLE;
          end else if (legal && (hit || wc_hit)) begin
            gnt  <= N_REQ'(1) << sel_own;
            hold <= '0;
            st   <= GRANT;
          end
        end
        GRANT: begin
          if (release_g) begin
            gnt     <= '0;
            timeout <= !done_g;
            st      <= en ? SCAN : IDLE;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) own[i] <= default_owner(i, N_REQ);
    end else if (cfg_we && (int'(cfg_slot) < NS) && (int'(cfg_owner) < N_REQ)) begin
      own[cfg_slot] <= cfg_owner;
    end
  end

endmodule

// File: tb/tb_jc_slot_sched.sv
// Bench for jc_slot_sched: random traffic against a slot-level reference model plus directed scenarios.
module tb_jc_slot_sched;

  localparam int N_REQ    = 4;
  localparam int STAGES   = jc_pkg::STAGES_DFLT;
  localparam int HOLD_MAX = 8;
  localparam int NS       = jc_pkg::NSLOTS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_slot = '0;
  logic [2:0]  cfg_owner = '0;
  logic [3:0]  req = '0;
  logic [3:0]  done = '0;
  logic [3:0]  gnt;
  logic [3:0]  slot;
  logic [4:0]  jstate;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: slot as a plain integer, table as an array.
  int m_st;
  int m_slot;
  int m_g;
  int m_hold;
  int m_to;
  int m_tbl [NS];

  always #5 clk = ~clk;

  jc_slot_sched #(.N_REQ(N_REQ), .STAGES(STAGES), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_slot  (cfg_slot),
    .cfg_owner (cfg_owner),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .slot      (slot),
    .jstate    (jstate),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_j(input int s);
    if (s < STAGES) return (32'd1 << s) - 32'd1;
    return (32'h1F << (s - STAGES)) & 32'h1F;
  endfunction

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; req = '0; done = '0; cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_st = 0; m_slot = 0; m_g = 0; m_hold = 0; m_to = 0;
    for (int i = 0; i < NS; i++) m_tbl[i] = i % N_REQ;
  endtask

  // One clock of the scheduling rules, applied to the inputs now driven.
  task automatic model_step();
    int  o;
    int  pick;
    bit  got;
    m_to = 0;
    case (m_st)
      0: if (en) m_st = 1;
      1: begin
        if (!en) begin
          m_st = 0;
        end else begin
          o = m_tbl[m_slot];
          got = 1'b0;
          pick = o;
          if (bit_of(req, o)) got = 1'b1;
`ifdef JC_WORK_CONSERVE_EN
          for (int k = 1; k < N_REQ; k++) begin
            if (!got && bit_of(req, (o + k) % N_REQ)) begin
              pick = (o + k) % N_REQ;
              got = 1'b1;
            end
          end
`endif
          if (got) begin
            m_g = pick; m_hold = 0; m_st = 2;
          end else begin
            m_slot = (m_slot + 1) % NS;
          end
        end
      end
      default: begin
        if (bit_of(done, m_g) || m_hold == HOLD_MAX - 1) begin
          m_to   = bit_of(done, m_g) ? 0 : 1;
          m_slot = (m_slot + 1) % NS;
          m_st   = en ? 1 : 0;
        end else begin
          m_hold++;
        end
      end
    endcase
    if (cfg_we && cfg_slot < NS && cfg_owner < N_REQ) m_tbl[cfg_slot] = cfg_owner;
  endtask

  task automatic model_check();
    chk("gnt", gnt, (m_st == 2) ? (32'd1 << m_g) : 32'd0);
    chk("busy", busy, (m_st == 2) ? 32'd1 : 32'd0);
    chk("slot", slot, m_slot);
    chk("jstate", jstate, exp_j(m_slot));
    chk("timeout", timeout, m_to);
  endtask

  task automatic wait_gnt(input string tag, input int lim, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hi;
    int tdm_exp [4];
    tdm_exp = '{0, 3, 4, 8};

    // Randomized run against the model; first iteration checks reset state.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      model_check();
      en        = ($urandom_range(0, 19) != 0);
      req       = 4'($urandom);
      done      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_slot  = 4'($urandom);
      cfg_owner = 3'($urandom);
      model_step();
      @(negedge clk);
    end
    cfg_we = 1'b0; done = '0;

    // Reset mid-grant: gnt drops without waiting for a clock.
    en = 1'b1; req = 4'hF;
    wait_gnt("mid", 30, cyc);
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_j", jstate, 0);
    chk("arst_slot", slot, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; req = '0;
    @(negedge clk);
    chk("arst_idle", busy, 0);

    // Default table must be back: owners 0,1,2,3,0,1,2,3,0,1 then wrap.
    en = 1'b1; req = 4'hF;
    for (int k = 0; k < 10; k++) begin
      wait_gnt("ord", 20, cyc);
      chk("ord_gnt", gnt, 32'd1 << (k % 4));
      chk("ord_slot", slot, k);
      done = gnt;
      @(negedge clk);
      done = '0;
      chk("ord_rel", gnt, 0);
    end
    chk("wrap_slot", slot, 0);
    chk("wrap_j", jstate, 0);

    // Strict TDM with slot 3 reassigned to requester 0.
    do_reset();
    cfg_we = 1'b1; cfg_slot = 4'd3; cfg_owner = 3'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    en = 1'b1; req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("tdm", 30, cyc);
      chk("tdm_slot", slot, tdm_exp[k]);
      if (k > 0) chk("tdm_gap", cyc, tdm_exp[k] - tdm_exp[k-1]);
      done = 4'b0001;
      @(negedge clk);
      done = '0;
    end

    // Hold timeout: exactly HOLD_MAX cycles of grant, then one timeout pulse.
    do_reset();
    en = 1'b1; req = 4'b0010;
    wait_gnt("hold", 20, cyc);
    chk("hold_gnt", gnt, 4'b0010);
    chk("hold_slot0", slot, 1);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt == '0) break;
      hi++;
    end
    chk("hold_len", hi, HOLD_MAX);
    chk("hold_to", timeout, 1);
    chk("hold_slot", slot, 2);
    @(negedge clk);
    chk("hold_to_clr", timeout, 0);

    // Illegal ring code is cleared on the next clock with no grant.
    do_reset();
    en = 1'b1; req = '0;
    repeat (3) @(negedge clk);
    force dut.u_ring.jq = 5'b10101;
    #1 release dut.u_ring.jq;
    req = 4'hF;
    @(negedge clk);
    chk("ill_j", jstate, 0);
    chk("ill_slot", slot, 0);
    chk("ill_gnt", gnt, 0);
    @(negedge clk);
    chk("ill_after", gnt, 4'b0001);

    // Idle owner at slot 0 with only requester 2 asking.
    do_reset();
    en = 1'b1; req = 4'b0100;
    wait_gnt("wc", 20, cyc);
    chk("wc_gnt", gnt, 4'b0100);
`ifdef JC_WORK_CONSERVE_EN
    chk("wc_slot", slot, 0);
    chk("wc_cyc", cyc, 2);
`else
    chk("wc_slot", slot, 2);
    chk("wc_cyc", cyc, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
